// File: rtl/fp_sigmoid_pkg.sv
// Shared types and constants for the sigmoid issue/retire stage.
package fp_sigmoid_pkg;

  localparam int unsigned TAG_MAX = 16;
  localparam int unsigned FP_MAX  = 80;

  typedef struct packed {
    logic               valid;
    logic               nan;
    logic [TAG_MAX-1:0] tag;
  } pipe_ent_t;

  // Exponent width for each supported operand format.
  function automatic int unsigned fp_exp_w(input int unsigned fpwid);
    case (fpwid)
      40:      return 10;
      64:      return 11;
      80:      return 15;
      default: return 8;
    endcase
  endfunction

  // Positive quiet NaN: all-ones exponent, mantissa MSB set, remaining bits clear.
  function automatic logic [FP_MAX-1:0] fp_qnan(input int unsigned fpwid);
    logic [FP_MAX-1:0] v;
    int unsigned       ew;
    v  = '0;
    ew = fp_exp_w(fpwid);
    for (int unsigned i = 0; i < ew; i++) v[fpwid-2-i] = 1'b1;
    v[fpwid-2-ew] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_sigmoid_fifo.sv
// Show-ahead result FIFO; head entry is visible whenever the FIFO is not empty.
module fp_sigmoid_fifo #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdat,
  input  logic         i_rd,
  output logic [W-1:0] o_rdat,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic          w_full;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_rdat  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_wr) begin
        r_mem[r_wp[AW-1:0]] <= i_wdat;
        r_wp                <= r_wp + PW'(1);
      end
      if (i_rd) r_rp <= r_rp + PW'(1);
    end
  end

  // Credit accounting upstream guarantees a write never lands on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(i_wr && w_full)) else $error("fp_sigmoid_fifo: write while full");
  end

endmodule

// File: rtl/fp_sigmoid_issue.sv
// Valid/ready wrapper around the fixed-latency sigmoid unit with a credit-guarded result FIFO.
// Optional NaN bypass enabled by defining FPSIG_NAN_BYPASS_EN.
module fp_sigmoid_issue
  import fp_sigmoid_pkg::*;
#(
  parameter int unsigned FPWID   = 32,
  parameter int unsigned SIG_LAT = 3,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_v,
  output logic             req_rdy,
  input  logic [FPWID-1:0] req_a,
  input  logic [TAGW-1:0]  req_tag,
  output logic             sig_ce,
  output logic [FPWID-1:0] sig_a,
  input  logic [FPWID-1:0] sig_o,
  output logic             res_v,
  input  logic             res_rdy,
  output logic [FPWID-1:0] res_o,
  output logic [TAGW-1:0]  res_tag
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned FW = FPWID + TAGW;

  logic [CW-1:0]    r_cnt;
  logic [FPWID-1:0] r_sig_a;
  pipe_ent_t        r_pipe [SIG_LAT+1];

  logic             w_acc;
  logic             w_pop;
  logic             w_nan;
  logic             w_empty;
  pipe_ent_t        w_last;
  logic [FPWID-1:0] w_res;
  logic [FW-1:0]    w_wdat;
  logic [FW-1:0]    w_rdat;

  assign req_rdy = !rst && (r_cnt < CW'(DEPTH));
  assign w_acc   = req_v && req_rdy;
  assign w_pop   = res_v && res_rdy;
  assign sig_ce  = 1'b1;
  assign sig_a   = r_sig_a;
  assign w_last  = r_pipe[SIG_LAT];

`ifdef FPSIG_NAN_BYPASS_EN
  localparam int unsigned       EW   = fp_exp_w(FPWID);
  localparam logic [FP_MAX-1:0] QNAN = fp_qnan(FPWID);

  assign w_nan = (&req_a[FPWID-2 -: EW]) && (|req_a[FPWID-2-EW:0]);
  assign w_res = w_last.nan ? {sig_o[FPWID-1], QNAN[FPWID-2:0]} : sig_o;
`else
  assign w_nan = 1'b0;
  assign w_res = sig_o;
`endif

  assign w_wdat = {TAGW'(w_last.tag), w_res};

  // Operand register and valid/tag shift pipe aligned to the unit's latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_a <= '0;
      for (int unsigned i = 0; i <= SIG_LAT; i++) r_pipe[i] <= '0;
    end else begin
      if (w_acc) r_sig_a <= req_a;
      r_pipe[0] <= '{valid: w_acc, nan: w_acc && w_nan, tag: TAG_MAX'(req_tag)};
      for (int unsigned i = 1; i <= SIG_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Credits cover both in-flight and stored results.
  always_ff @(posedge clk) begin
    if (rst)                  r_cnt <= '0;
    else if (w_acc && !w_pop) r_cnt <= r_cnt + CW'(1);
    else if (!w_acc && w_pop) r_cnt <= r_cnt - CW'(1);
  end

  fp_sigmoid_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_last.valid),
    .i_wdat  (w_wdat),
    .i_rd    (w_pop),
    .o_rdat  (w_rdat),
    .o_empty (w_empty)
  );

  assign res_v   = !w_empty;
  assign res_o   = w_rdat[FPWID-1:0];
  assign res_tag = w_rdat[FW-1:FPWID];

endmodule

// File: tb/tb_fp_sigmoid_issue.sv
// Bench for fp_sigmoid_issue: stub sigmoid unit plus an in-order expected-result queue.
module tb_fp_sigmoid_issue;

  localparam int unsigned FPWID   = 32;
  localparam int unsigned SIG_LAT = 3;
  localparam int unsigned TAGW    = 4;
  localparam int unsigned DEPTH   = 4;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             req_v   = 1'b0;
  logic             req_rdy;
  logic [FPWID-1:0] req_a   = '0;
  logic [TAGW-1:0]  req_tag = '0;
  logic             sig_ce;
  logic [FPWID-1:0] sig_a;
  logic [FPWID-1:0] sig_o;
  logic             res_v;
  logic             res_rdy = 1'b0;
  logic [FPWID-1:0] res_o;
  logic [TAGW-1:0]  res_tag;

  logic [FPWID-1:0] stub [SIG_LAT];

  always #5 clk = ~clk;

  // Sigmoid stand-in: operand XOR 1, SIG_LAT register stages.
  always @(posedge clk) begin
    stub[0] <= sig_a ^ 32'h1;
    for (int i = 1; i < SIG_LAT; i++) stub[i] <= stub[i-1];
  end
  assign sig_o = stub[SIG_LAT-1];

  fp_sigmoid_issue #(
    .FPWID   (FPWID),
    .SIG_LAT (SIG_LAT),
    .TAGW    (TAGW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_v   (req_v),
    .req_rdy (req_rdy),
    .req_a   (req_a),
    .req_tag (req_tag),
    .sig_ce  (sig_ce),
    .sig_a   (sig_a),
    .sig_o   (sig_o),
    .res_v   (res_v),
    .res_rdy (res_rdy),
    .res_o   (res_o),
    .res_tag (res_tag)
  );

  typedef struct {
    logic [TAGW-1:0]  tag;
    logic [FPWID-1:0] data;
    int               rdy_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;

  function automatic logic [FPWID-1:0] model(input logic [FPWID-1:0] a);
`ifdef FPSIG_NAN_BYPASS_EN
    if ((&a[30:23]) && (|a[22:0])) return {a[31], 8'hFF, 1'b1, 22'h0};
`endif
    return a ^ 32'h1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, advance the model, wait for next negedge.
  task automatic tick(input logic v, input logic [FPWID-1:0] a, input logic [TAGW-1:0] t,
                      input logic rr, input logic r, output logic acc);
    logic exp_rdy;
    logic exp_rv;
    exp_t e;
    rst = r; req_v = v; req_a = a; req_tag = t; res_rdy = rr;
    #1;
    exp_rdy = !r && (q.size() < DEPTH);
    chk("req_rdy", req_rdy, exp_rdy);
    exp_rv = 1'b0;
    if (!r) begin
      exp_rv = (q.size() > 0) && (q[0].rdy_cyc <= cyc);
      chk("res_v", res_v, exp_rv);
      chk("cnt", dut.r_cnt, q.size());
      if (exp_rv) begin
        chk("res_o", res_o, q[0].data);
        chk("res_tag", res_tag, q[0].tag);
      end
    end
    if (v && req_rdy) n_acc++;
    acc = v && exp_rdy;
    if (r) q.delete();
    else begin
      if (exp_rv && rr) void'(q.pop_front());
      if (acc) begin
        e.tag = t; e.data = model(a); e.rdy_cyc = cyc + SIG_LAT + 2;
        q.push_back(e);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, rr, 1'b0, acc);
  endtask

  initial begin
    logic             acc;
    logic [FPWID-1:0] a;
    int               guard;

    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, 1'b0, 1'b1, acc);
    idle(1, 1'b0);
    chk("reset_sig_a", sig_a, 32'h0);
    chk("reset_sig_ce", sig_ce, 1'b1);
    chk("reset_res_v", res_v, 1'b0);
    chk("reset_res_o", res_o, 32'h0);

    // Single request
    tick(1'b1, 32'h3F800000, 4'd5, 1'b1, 1'b0, acc);
    idle(7, 1'b1);

    // Streaming tags 0..15
    guard = 0;
    for (int i = 0; i < 16 && guard < 200; guard++) begin
      a = $urandom;
      tick(1'b1, a, TAGW'(i), 1'b1, 1'b0, acc);
      if (acc) i++;
    end
    chk("stream_guard", guard < 200, 1'b1);
    idle(8, 1'b1);

    // Backpressure
    n_acc = 0;
    for (int i = 0; i < 8; i++) tick(1'b1, $urandom, TAGW'(8 + i), 1'b0, 1'b0, acc);
    chk("bp_accepts", n_acc, 4);
    idle(10, 1'b1);

    // Accept and pop together with one stored entry
    tick(1'b1, 32'h12345678, 4'd3, 1'b0, 1'b0, acc);
    idle(6, 1'b0);
    tick(1'b1, 32'h0BADF00D, 4'd4, 1'b1, 1'b0, acc);
    idle(8, 1'b1);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) tick(1'b1, $urandom, TAGW'(i + 1), 1'b1, 1'b0, acc);
    tick(1'b0, '0, '0, 1'b1, 1'b1, acc);
    idle(8, 1'b1);
    tick(1'b1, 32'hC0000000, 4'd9, 1'b1, 1'b0, acc);
    idle(8, 1'b1);

    // NaN operand
    tick(1'b1, 32'h7FC00001, 4'd2, 1'b1, 1'b0, acc);
    idle(6, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a[30:23] = 8'hFF;
      tick($urandom_range(0, 3) != 0, a, TAGW'($urandom), $urandom_range(0, 3) != 0, 1'b0, acc);
    end
    idle(12, 1'b1);
    chk("drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
